// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port.
// Accepts one load or store, waits WAIT_CYCLES cycles, then returns a
// single-cycle Ready pulse together with the aligned word and an error flag.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        AccessErr,
  output logic        Busy
);

  localparam int unsigned IDX_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 32'd1) ? $clog2(WAIT_CYCLES) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((WAIT_CYCLES > 32'd0) ? (WAIT_CYCLES - 32'd1) : 32'd0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Byte enables for a store: byte -> one lane, half -> lower/upper pair, word -> all.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across lanes so the enables pick the right copy.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_data = {4{wdata[7:0]}};
      2'b01:   lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  // Misaligned, out-of-range or both-operations-at-once requests are rejected.
  function automatic logic access_err(input logic rd, input logic wr,
                                      input logic [31:0] addr, input logic [1:0] size);
    logic half_mis;
    logic word_mis;
    logic out_rng;
    half_mis   = (size == 2'b01) && addr[0];
    word_mis   = size[1] && (addr[1:0] != 2'b00);
    out_rng    = ({2'b00, addr[31:2]} >= 32'(DEPTH));
    access_err = half_mis || word_mis || out_rng || (rd && wr);
  endfunction

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_q;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;
  logic [31:0]       mem_q [DEPTH];

  logic              req_s;
  logic              eff_rd_d;
  logic              eff_wr_d;
  logic [31:0]       eff_addr_d;
  logic [31:0]       eff_wdata_d;
  logic [1:0]        eff_size_d;
  logic              err_d;
  logic [IDX_W-1:0]  idx_d;
  logic [3:0]        be_d;
  logic [31:0]       lanes_d;
  logic [31:0]       old_word_d;
  logic [31:0]       word_d;
  logic              enter_resp_d;
  logic              commit_d;

  assign req_s = MemRead || MemWrite;

  // Select the request being completed: live inputs when finishing straight from IDLE, else the latched copy.
  always_comb begin
    eff_rd_d    = rd_q;
    eff_wr_d    = wr_q;
    eff_addr_d  = addr_q;
    eff_wdata_d = wdata_q;
    eff_size_d  = size_q;
    if (state_q == S_IDLE) begin
      eff_rd_d    = MemRead;
      eff_wr_d    = MemWrite;
      eff_addr_d  = Addr;
      eff_wdata_d = WriteData;
      eff_size_d  = Size;
    end else begin
      eff_rd_d    = rd_q;
      eff_wr_d    = wr_q;
      eff_addr_d  = addr_q;
      eff_wdata_d = wdata_q;
      eff_size_d  = size_q;
    end
  end

  // Error flag, lane merge and commit decision for the access about to enter RESP.
  always_comb begin
    err_d      = access_err(eff_rd_d, eff_wr_d, eff_addr_d, eff_size_d);
    idx_d      = eff_addr_d[IDX_W+1:2];
    old_word_d = mem_q[idx_d];
    lanes_d    = lane_data(eff_size_d, eff_wdata_d);
    be_d       = eff_wr_d ? byte_en(eff_size_d, eff_addr_d[1:0]) : 4'b0000;
    word_d     = old_word_d;
    for (int i = 0; i < 4; i++) begin
      if (be_d[i]) begin
        word_d[8*i +: 8] = lanes_d[8*i +: 8];
      end else begin
        word_d[8*i +: 8] = old_word_d[8*i +: 8];
      end
    end
    if (state_q == S_IDLE) begin
      enter_resp_d = req_s && (WAIT_CYCLES == 32'd0);
    end else if (state_q == S_WAIT) begin
      enter_resp_d = (cnt_q == CNT_LAST);
    end else begin
      enter_resp_d = 1'b0;
    end
    commit_d = enter_resp_d && !reset && eff_wr_d && !err_d;
  end

  // Control FSM with registered Ready/AccessErr/ReadData/Busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (req_s) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            addr_q  <= Addr;
            wdata_q <= WriteData;
            size_q  <= Size;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            if (enter_resp_d) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              err_q   <= err_d;
              rdata_q <= err_d ? 32'd0 : word_d;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (enter_resp_d) begin
            cnt_q   <= '0;
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= err_d;
            rdata_q <= err_d ? 32'd0 : word_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Memory array: not cleared by reset, written only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (commit_d) begin
      mem_q[idx_d] <= word_d;
    end
  end

  assign ReadData  = rdata_q;
  assign Ready     = ready_q;
  assign AccessErr = err_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state,
// one with zero wait states driven back-to-back.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_rd, a_wr, a_ready, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_size;
  logic        b_rd, b_wr, b_ready, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_size;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr), .Addr(a_addr),
    .WriteData(a_wdata), .Size(a_size), .ReadData(a_rdata), .Ready(a_ready),
    .AccessErr(a_err), .Busy(a_busy)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr), .Addr(b_addr),
    .WriteData(b_wdata), .Size(b_size), .ReadData(b_rdata), .Ready(b_ready),
    .AccessErr(b_err), .Busy(b_busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance A: hold the request until Ready, then score it.
  task automatic access_a(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic [31:0] exp_rd,
                          input logic exp_err);
    exp_t e;
    exp_t got;
    int   cyc;
    logic seen;
    @(negedge clk);
    a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; a_size = size;
    e.tag = tag; e.rd = exp_rd; e.err = exp_err;
    sb_a.push_back(e);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({tag, ".busy"}, 32'(a_busy), 32'd1);
      if (a_ready) seen = 1'b1;
    end
    a_rd = 1'b0; a_wr = 1'b0;
    check({tag, ".ready_seen"}, 32'(seen), 32'd1);
    if (seen && sb_a.size() > 0) begin
      got = sb_a.pop_front();
      check({got.tag, ".rdata"}, a_rdata, got.rd);
      check({got.tag, ".err"}, 32'(a_err), 32'(got.err));
      check({got.tag, ".latency"}, 32'(cyc), 32'd2);
    end
    @(posedge clk); #1;
    check({tag, ".ready_drop"}, 32'(a_ready), 32'd0);
    check({tag, ".busy_drop"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    logic        bw [5];
    logic [31:0] ba [5];
    logic [31:0] bd [5];
    logic [1:0]  bs [5];
    logic [31:0] be [5];
    exp_t e;
    exp_t got;
    int   idx;
    int   last;
    int   cyc;

    reset = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_size = 2'b00;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_size = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rdata", a_rdata, 32'd0);
    check("rst.ready", 32'(a_ready), 32'd0);
    check("rst.err", 32'(a_err), 32'd0);
    check("rst.busy", 32'(a_busy), 32'd0);
    check("rst.b_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic store/load with one wait state
    access_a("st64", 1'b0, 1'b1, 32'h64, 32'h19, 2'b10, 32'h00000019, 1'b0);
    access_a("ld64", 1'b1, 1'b0, 32'h64, 32'h0, 2'b10, 32'h00000019, 1'b0);

    // Byte lanes
    access_a("st20w", 1'b0, 1'b1, 32'h20, 32'h11223344, 2'b10, 32'h11223344, 1'b0);
    access_a("st22b", 1'b0, 1'b1, 32'h22, 32'h000000AA, 2'b00, 32'h11AA3344, 1'b0);
    access_a("ld20a", 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 32'h11AA3344, 1'b0);
    access_a("st20h", 1'b0, 1'b1, 32'h20, 32'h0000BEEF, 2'b01, 32'h11AABEEF, 1'b0);
    access_a("ld20b", 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 32'h11AABEEF, 1'b0);
    access_a("st30s3", 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 2'b11, 32'hCAFEF00D, 1'b0);

    // Misalignment
    access_a("st66w", 1'b0, 1'b1, 32'h66, 32'hFFFFFFFF, 2'b10, 32'h0, 1'b1);
    access_a("st65h", 1'b0, 1'b1, 32'h65, 32'h00001234, 2'b01, 32'h0, 1'b1);
    access_a("ld64b", 1'b1, 1'b0, 32'h64, 32'h0, 2'b10, 32'h00000019, 1'b0);
    access_a("st66h", 1'b0, 1'b1, 32'h66, 32'h00001234, 2'b01, 32'h12340019, 1'b0);
    access_a("ld64c", 1'b1, 1'b0, 32'h64, 32'h0, 2'b10, 32'h12340019, 1'b0);

    // Range and ill-formed
    access_a("ld100", 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 32'h0, 1'b1);
    access_a("both64", 1'b1, 1'b1, 32'h64, 32'h55555555, 2'b10, 32'h0, 1'b1);
    access_a("ld64d", 1'b1, 1'b0, 32'h64, 32'h0, 2'b10, 32'h12340019, 1'b0);

    // Reset pulsed while the store waits
    @(negedge clk);
    a_rd = 1'b0; a_wr = 1'b1; a_addr = 32'h64; a_wdata = 32'hDEADBEEF; a_size = 2'b10;
    @(posedge clk); #1;
    check("rstw.busy", 32'(a_busy), 32'd1);
    reset = 1'b1; a_wr = 1'b0;
    @(posedge clk); #1;
    check("rstw.ready", 32'(a_ready), 32'd0);
    check("rstw.busy_off", 32'(a_busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstw.no_ready", 32'(a_ready), 32'd0);
    end
    access_a("ld64e", 1'b1, 1'b0, 32'h64, 32'h0, 2'b10, 32'h12340019, 1'b0);

    // Zero wait states, request held continuously
    bw[0] = 1'b1; ba[0] = 32'h0; bd[0] = 32'hA5A50001; bs[0] = 2'b10; be[0] = 32'hA5A50001;
    bw[1] = 1'b1; ba[1] = 32'h4; bd[1] = 32'h000000FF; bs[1] = 2'b10; be[1] = 32'h000000FF;
    bw[2] = 1'b1; ba[2] = 32'h5; bd[2] = 32'h00000077; bs[2] = 2'b00; be[2] = 32'h000077FF;
    bw[3] = 1'b0; ba[3] = 32'h0; bd[3] = 32'h0;        bs[3] = 2'b10; be[3] = 32'hA5A50001;
    bw[4] = 1'b0; ba[4] = 32'h4; bd[4] = 32'h0;        bs[4] = 2'b10; be[4] = 32'h000077FF;
    @(negedge clk);
    idx = 0;
    b_wr = bw[0]; b_rd = !bw[0]; b_addr = ba[0]; b_wdata = bd[0]; b_size = bs[0];
    e.tag = "b2b0"; e.rd = be[0]; e.err = 1'b0;
    sb_b.push_back(e);
    last = 0;
    cyc  = 0;
    while (idx < 5 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (b_ready) begin
        if (sb_b.size() > 0) begin
          got = sb_b.pop_front();
          check({got.tag, ".rdata"}, b_rdata, got.rd);
          check({got.tag, ".err"}, 32'(b_err), 32'(got.err));
        end
        if (idx > 0) check("b2b.period", 32'(cyc - last), 32'd2);
        last = cyc;
        idx++;
        if (idx < 5) begin
          b_wr = bw[idx]; b_rd = !bw[idx]; b_addr = ba[idx]; b_wdata = bd[idx]; b_size = bs[idx];
          e.tag = $sformatf("b2b%0d", idx); e.rd = be[idx]; e.err = 1'b0;
          sb_b.push_back(e);
        end else begin
          b_wr = 1'b0; b_rd = 1'b0;
        end
      end
    end
    check("b2b.count", 32'(idx), 32'd5);
    check("b2b.first_latency", 32'(last - 8), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
